// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: a per-instruction FSM
// that drives the datapath muxes, handshakes with shared memory and counts retires.
module multicycle_control #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_half,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       aluc,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] instr_count,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_RWB    = 4'd3,
    S_EXEC_I = 4'd4,
    S_IWB    = 4'd5,
    S_BRANCH = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_LDWB   = 4'd9,
    S_MEM_WR = 4'd10,
    S_TRAP   = 4'd11
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [TO_W-1:0]  toCnt;
  logic [CNT_W-1:0] instrCountQ;
  logic             trapQ;
  logic [1:0]       trapCauseQ;
  logic [1:0]       causeNext;
  logic             retire;
  logic             toHit;
  logic             rFuncOk;
  logic [2:0]       rAluc;
  logic [2:0]       iAluc;

  // Registered control outputs, loaded with the decode of the state being entered
  logic       memReqQ, memWeQ, memHalfQ, iOrDQ, fetchQ, pcWriteCondQ, pcSourceQ;
  logic       aluSrcAQ, regWriteQ, regDstQ, memToRegQ;
  logic [1:0] aluSrcBQ;
  logic [2:0] alucQ;
  logic       memReqN, memWeN, memHalfN, iOrDN, fetchN, pcWriteCondN, pcSourceN;
  logic       aluSrcAN, regWriteN, regDstN, memToRegN;
  logic [1:0] aluSrcBN;
  logic [2:0] alucN;

  // R-type function field decode
  always_comb begin
    rFuncOk = 1'b1;
    rAluc   = ALU_ADD;
    case (func)
      6'b100000: rAluc = ALU_ADD;
      6'b100010: rAluc = ALU_SUB;
      6'b000000: rAluc = ALU_SLL;
      6'b000010: rAluc = ALU_SRL;
      6'b100100: rAluc = ALU_AND;
      6'b100101: rAluc = ALU_OR;
      6'b101010: rAluc = ALU_SLT;
      default:   rFuncOk = 1'b0;
    endcase
  end

  always_comb begin
    iAluc = ALU_ADD;
    if (opcode == OP_ANDI) iAluc = ALU_AND;
    else if (opcode == OP_ORI) iAluc = ALU_OR;
  end

  // Next state, retire strobe and next-cycle control decode
  always_comb begin
    stateNext    = state;
    causeNext    = trapCauseQ;
    retire       = 1'b0;
    toHit        = (toCnt == TO_LAST) && !mem_ready;
    memReqN      = 1'b0;
    memWeN       = 1'b0;
    memHalfN     = 1'b0;
    iOrDN        = 1'b0;
    fetchN       = 1'b0;
    pcWriteCondN = 1'b0;
    pcSourceN    = 1'b0;
    aluSrcAN     = 1'b0;
    aluSrcBN     = 2'b00;
    alucN        = ALU_ADD;
    regWriteN    = 1'b0;
    regDstN      = 1'b0;
    memToRegN    = 1'b0;

    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          stateNext = S_DECODE;
        end else if (toHit) begin
          stateNext = S_TRAP;
          causeNext = 2'b10;
        end
      end
      S_DECODE: begin
        if (opcode == OP_RTYPE && rFuncOk) begin
          stateNext = S_EXEC_R;
        end else if (opcode == OP_BEQ) begin
          stateNext = S_BRANCH;
        end else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) begin
          stateNext = S_EXEC_I;
        end else if (opcode == OP_LW || opcode == OP_LH || opcode == OP_SW) begin
          stateNext = S_ADDR;
        end else begin
          stateNext = S_TRAP;
          causeNext = 2'b01;
        end
      end
      S_EXEC_R: stateNext = S_RWB;
      S_EXEC_I: stateNext = S_IWB;
      S_RWB, S_IWB, S_BRANCH, S_LDWB: begin
        retire    = 1'b1;
        stateNext = S_FETCH;
      end
      S_ADDR: stateNext = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          stateNext = S_LDWB;
        end else if (toHit) begin
          stateNext = S_TRAP;
          causeNext = 2'b10;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          retire    = 1'b1;
          stateNext = S_FETCH;
        end else if (toHit) begin
          stateNext = S_TRAP;
          causeNext = 2'b10;
        end
      end
      S_TRAP:  stateNext = S_TRAP;
      default: stateNext = S_FETCH;
    endcase

    case (stateNext)
      S_FETCH: begin
        memReqN  = 1'b1;
        fetchN   = 1'b1;
        aluSrcBN = 2'b01;
      end
      S_DECODE: aluSrcBN = 2'b11;
      S_EXEC_R: begin
        aluSrcAN = 1'b1;
        alucN    = rAluc;
      end
      S_RWB: begin
        regWriteN = 1'b1;
        regDstN   = 1'b1;
      end
      S_EXEC_I: begin
        aluSrcAN = 1'b1;
        aluSrcBN = 2'b10;
        alucN    = iAluc;
      end
      S_IWB: regWriteN = 1'b1;
      S_BRANCH: begin
        aluSrcAN     = 1'b1;
        alucN        = ALU_SUB;
        pcWriteCondN = 1'b1;
        pcSourceN    = 1'b1;
      end
      S_ADDR: begin
        aluSrcAN = 1'b1;
        aluSrcBN = 2'b10;
      end
      S_MEM_RD: begin
        memReqN  = 1'b1;
        iOrDN    = 1'b1;
        memHalfN = (opcode == OP_LH);
      end
      S_LDWB: begin
        regWriteN = 1'b1;
        memToRegN = 1'b1;
        memHalfN  = (opcode == OP_LH);
      end
      S_MEM_WR: begin
        memReqN = 1'b1;
        memWeN  = 1'b1;
        iOrDN   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset parks the output registers at the FETCH decode; rst gating below keeps them quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      toCnt        <= '0;
      instrCountQ  <= '0;
      trapQ        <= 1'b0;
      trapCauseQ   <= 2'b00;
      memReqQ      <= 1'b1;
      memWeQ       <= 1'b0;
      memHalfQ     <= 1'b0;
      iOrDQ        <= 1'b0;
      fetchQ       <= 1'b1;
      pcWriteCondQ <= 1'b0;
      pcSourceQ    <= 1'b0;
      aluSrcAQ     <= 1'b0;
      aluSrcBQ     <= 2'b01;
      alucQ        <= ALU_ADD;
      regWriteQ    <= 1'b0;
      regDstQ      <= 1'b0;
      memToRegQ    <= 1'b0;
    end else begin
      state      <= stateNext;
      trapCauseQ <= causeNext;
      trapQ      <= (stateNext == S_TRAP);
      if (retire) instrCountQ <= instrCountQ + CNT_W'(1);
      if (stateNext != state) toCnt <= '0;
      else if (memReqQ && !mem_ready) toCnt <= toCnt + TO_W'(1);
      memReqQ      <= memReqN;
      memWeQ       <= memWeN;
      memHalfQ     <= memHalfN;
      iOrDQ        <= iOrDN;
      fetchQ       <= fetchN;
      pcWriteCondQ <= pcWriteCondN;
      pcSourceQ    <= pcSourceN;
      aluSrcAQ     <= aluSrcAN;
      aluSrcBQ     <= aluSrcBN;
      alucQ        <= alucN;
      regWriteQ    <= regWriteN;
      regDstQ      <= regDstN;
      memToRegQ    <= memToRegN;
    end
  end

  assign mem_req       = memReqQ & ~rst;
  assign mem_we        = memWeQ;
  assign mem_half      = memHalfQ;
  assign i_or_d        = iOrDQ;
  assign ir_write      = fetchQ & mem_ready & ~rst;
  assign pc_write      = fetchQ & mem_ready & ~rst;
  assign pc_write_cond = pcWriteCondQ;
  assign pc_source     = pcSourceQ;
  assign alu_src_a     = aluSrcAQ;
  assign alu_src_b     = rst ? 2'b00 : aluSrcBQ;
  assign aluc          = alucQ;
  assign reg_write     = regWriteQ;
  assign reg_dst       = regDstQ;
  assign mem_to_reg    = memToRegQ;
  assign instr_count   = instrCountQ;
  assign trap          = trapQ;
  assign trap_cause    = trapCauseQ;

endmodule
